// File: rtl/dff_bank_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// The one-hot helper supports up to MAX_NREQ requesters.
package dff_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;
  localparam int MAX_NREQ     = 8;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: the first candidate at or after ptr wins.
// The search wraps modulo NREQ.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic [NREQ-1:0]         excl,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] cand;

  assign cand = req & ~excl;

  // Walk from the far end so the last hit written is the one closest to ptr.
  always_comb begin : search
    logic [IW-1:0] k;
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % NREQ);
      if (cand[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter that owns the write port of a shared register bank.
// A locked burst is capped at MAX_HOLD beats so the other requesters are always served.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  reg_en,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  busy
);

  localparam int             IW         = $clog2(NREQ);
  localparam int             CW         = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NREQ - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   w_reg, w_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   ptr_inc, pick_ptr, pick_idx;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] w_onehot, pick_excl;
  logic [WIDTH-1:0] reg_d_reg, reg_d_next;
  logic            pick_valid;
  logic            continue_burst;
  logic [WIDTH-1:0] wdata_slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wdata_slice[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // While writing, the current owner is excluded and the search starts just past it.
  assign ptr_inc   = (w_reg == LAST_IDX) ? '0 : w_reg + IW'(1);
  assign w_onehot  = NREQ'(onehot(3'(w_reg)));
  assign pick_ptr  = (state_reg == WRITE) ? ptr_inc : ptr_reg;
  assign pick_excl = (state_reg == WRITE) ? w_onehot : '0;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .excl (pick_excl),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign continue_burst = (state_reg == WRITE) && lock[w_reg] && req[w_reg]
                          && (beat_cnt_reg < HOLD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      w_reg        <= '0;
      ptr_reg      <= '0;
      beat_cnt_reg <= '0;
      gnt_reg      <= '0;
      reg_d_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      w_reg        <= w_next;
      ptr_reg      <= ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      gnt_reg      <= gnt_next;
      reg_d_reg    <= reg_d_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    w_next        = w_reg;
    ptr_next      = ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next    = WRITE;
          w_next        = pick_idx;
          beat_cnt_next = CW'(1);
        end
      end
      WRITE: begin
        if (continue_burst) begin
          beat_cnt_next = beat_cnt_reg + CW'(1);
        end else begin
          // Release, whether voluntary or forced by the hold limit.
          ptr_next = ptr_inc;
          if (pick_valid) begin
            w_next        = pick_idx;
            beat_cnt_next = CW'(1);
          end else begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    gnt_next   = '0;
    reg_d_next = '0;
    if (state_next == WRITE) begin
      gnt_next   = NREQ'(onehot(3'(w_next)));
      reg_d_next = wdata_slice[w_next];
    end
  end

  assign gnt    = gnt_reg;
  assign ack    = gnt_reg;
  assign reg_en = |gnt_reg;
  assign reg_d  = reg_d_reg;
  assign busy   = (state_reg == WRITE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: directed beats are queued with their cycle,
// and a negedge monitor pops and compares them and also checks the output invariants.
module tb_dff_bank_arbiter;

  localparam int NREQ         = 4;
  localparam int WIDTH        = 8;
  localparam int MAX_HOLD     = 4;
  localparam int STARVE_LIMIT = (NREQ - 1) * MAX_HOLD + 1;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ-1:0]       lock  = '0;
  logic [WIDTH-1:0]      wd [NREQ];
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt, ack;
  logic                  reg_en, busy;
  logic [WIDTH-1:0]      reg_d;

  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  dff_bank_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .ack(ack), .reg_en(reg_en), .reg_d(reg_d), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    rand_on = 1'b0;
  int    wait_cnt [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int idx, input logic [7:0] d);
    beat_t b;
    b.cyc  = cyc + 1;
    b.gnt  = 4'(1 << idx);
    b.data = d;
    exp_q.push_back(b);
    $display("issue: cycle %0d requester %0d data %0h", b.cyc, idx, d);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_reg_en"}, 32'(reg_en), 0);
    chk({tag, "_reg_d"}, 32'(reg_d), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    step();
    reset = 1'b0;
    chk_quiet("reset");
    chk("reset_ptr", 32'(dut.ptr_reg), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard on every beat.
  always @(negedge clk) begin
    beat_t b;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("ack_eq_gnt", 32'(ack), 32'(gnt));
    chk("reg_en_eq_or_gnt", 32'(reg_en), 32'(|gnt));
    chk("busy_eq_reg_en", 32'(busy), 32'(reg_en));
    if (!reg_en) chk("reg_d_zero_idle", 32'(reg_d), 0);
    if (!rand_on) begin
      if (reg_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 32'(reg_en), 0);
        end else begin
          b = exp_q.pop_front();
          chk("sb_cycle", 32'(cyc), 32'(b.cyc));
          chk("sb_gnt", 32'(gnt), 32'(b.gnt));
          chk("sb_data", 32'(reg_d), 32'(b.data));
          $display("beat: cycle %0d gnt %b data %0h", cyc, gnt, reg_d);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        b = exp_q.pop_front();
        chk("sb_missing_beat", 32'(reg_en), 1);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] || !req[i]) wait_cnt[i] = 0;
      else wait_cnt[i] = wait_cnt[i] + 1;
      if (rand_on && req[i]) chk("starve_bound", 32'(wait_cnt[i] <= STARVE_LIMIT), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int win3 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < NREQ; i++) begin
      wd[i]       = '0;
      wait_cnt[i] = 0;
    end

    // Reset for two cycles, then a single request.
    reset = 1'b1;
    step();
    do_reset();
    wd[0] = 8'hA5;
    req   = 4'b0001;
    push_beat(0, 8'hA5);
    step();
    req = '0;
    step();
    chk_quiet("single_then_idle");

    // Fairness: all four requesting, no lock.
    do_reset();
    for (int i = 0; i < NREQ; i++) wd[i] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      push_beat(n % 4, 8'h10 + 8'(n % 4));
      step();
    end
    req = '0;
    step();

    // Locked burst capped by the hold limit, fresh data each beat.
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int n = 0; n < 9; n++) begin
      wd[0] = 8'hC0 + 8'(n);
      wd[1] = 8'hD0 + 8'(n);
      push_beat(win3[n], (win3[n] == 0) ? 8'hC0 + 8'(n) : 8'hD0 + 8'(n));
      step();
    end
    req  = '0;
    lock = '0;
    step();

    // Burst ended early by dropping req under lock.
    do_reset();
    req   = 4'b1100;
    lock  = 4'b0100;
    wd[2] = 8'h21;
    wd[3] = 8'h31;
    push_beat(2, 8'h21);
    step();
    wd[2] = 8'h22;
    push_beat(2, 8'h22);
    step();
    req   = 4'b1000;
    wd[3] = 8'h33;
    push_beat(3, 8'h33);
    step();
    chk("early_end_ptr", 32'(dut.ptr_reg), 3);
    req  = '0;
    lock = '0;
    step();

    // Reset in the middle of a locked burst.
    do_reset();
    req   = 4'b0010;
    lock  = 4'b0010;
    wd[1] = 8'h51;
    push_beat(1, 8'h51);
    step();
    wd[1] = 8'h52;
    push_beat(1, 8'h52);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_quiet("midburst_reset");
    chk("midburst_reset_ptr", 32'(dut.ptr_reg), 0);
    wd[1] = 8'h53;
    push_beat(1, 8'h53);
    step();
    chk("regrant_beat_cnt", 32'(dut.beat_cnt_reg), 1);
    req  = '0;
    lock = '0;
    step();
    step();

    // Random traffic: invariants and starvation bound only.
    rand_on = 1'b1;
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom) | 4'($urandom);
      lock = 4'($urandom);
      for (int i = 0; i < NREQ; i++) wd[i] = 8'($urandom);
      step();
    end
    req  = '0;
    lock = '0;
    step();
    step();
    rand_on = 1'b0;
    step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
